// File: rtl/fetch_unit.sv
// Instruction fetch sequencer for the Nibbler core: fetches 1- or 2-byte instructions
// from ROM and hands them to execute. Optional macro FETCH_INSTR_COUNT_EN adds instr_count.
module fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              halt,
  output logic              pc_enable,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic [ADDR_W-1:0] target,
  output logic              is_long,
`ifdef FETCH_INSTR_COUNT_EN
  output logic [15:0]       instr_count,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_OP  = 2'd0,
    S_ARG = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_arg;
  logic              w_accept;
  logic              w_pc_enable;
  logic              w_pc_load;

  // Handshake: an instruction transfers on a cycle where instr_valid and instr_ready
  // are both high; instr_valid never drops and its payload never changes until then.
  assign w_accept    = instr_valid & instr_ready;
  assign instr_valid = (r_state == S_OUT) & ~reset;

  assign rom_addr    = pc_in;
  assign opcode      = r_ir[7:4];
  assign operand     = r_ir[3:0];
  assign is_long     = ~r_ir[7];
  assign target      = {r_ir[3:0], r_arg};
  assign pc_load_val = target;
  assign dbg_state   = r_state;

  always_comb begin
    w_next_state = r_state;
    w_pc_enable  = 1'b0;
    w_pc_load    = 1'b0;
    case (r_state)
      S_OP: begin
        if (!halt) begin
          w_pc_enable  = 1'b1;
          w_next_state = rom_data[7] ? S_OUT : S_ARG;
        end
      end
      S_ARG: begin
        w_pc_enable  = 1'b1;
        w_next_state = S_OUT;
      end
      S_OUT: begin
        if (w_accept) begin
          w_next_state = S_OP;
          w_pc_load    = is_long & branch_taken;
        end
      end
      default: w_next_state = S_OP;
    endcase
  end

  // Reset masks the PC controls so a discarded fetch cannot move the PC.
  assign pc_enable = w_pc_enable & ~reset;
  assign pc_load   = w_pc_load & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_OP;
      r_ir    <= '0;
      r_arg   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_OP && !halt) r_ir <= rom_data;
      if (r_state == S_ARG) r_arg <= rom_data;
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (reset) r_instr_count <= '0;
    else if (w_accept) r_instr_count <= r_instr_count + 16'd1;
  end

  assign instr_count = r_instr_count;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer between the 12-bit program counter and the execute/decode stage of the Nibbler core.
- Consumes the PC value, addresses the program ROM, captures 1- or 2-byte instructions and presents them to execute with a valid/ready handshake.
- Drives the PC's enable/load controls, including loading branch targets on taken jumps.

Parameters:
- ADDR_W, 12, program address width; matches PC width.
- DATA_W, 8, ROM word width; opcode = upper nibble, operand = lower nibble.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  ADDR_W  current PC value from the program counter.
- rom_addr  out  ADDR_W  ROM address; combinationally equal to pc_in.
- rom_data  in  DATA_W  ROM read data; combinational read of rom_addr in the same cycle.
- halt  in  1  holds fetch idle in S_OP; the PC does not advance.
- pc_enable  out  1  PC increment request.
- pc_load  out  1  PC load request.
- pc_load_val  out  ADDR_W  value loaded into the PC when pc_load=1.
- instr_valid  out  1  instruction presented to execute.
- instr_ready  in  1  execute accepts the presented instruction.
- branch_taken  in  1  sampled on accept of a long instruction; 1 = jump to target.
- opcode  out  4  ir[7:4].
- operand  out  4  ir[3:0].
- target  out  ADDR_W  {ir[3:0], arg[7:0]}; valid for long instructions only.
- is_long  out  1  1 when opcode[3]==0 (2-byte jump class).

Behaviour:
- Reset (reset=1 at posedge):
  - state <= S_OP; ir, arg <= 0; instr_valid=0.
  - pc_enable=0 and pc_load=0 for the whole reset cycle, regardless of state.
  - Reset has priority over every other input, including mid-instruction. Any partially fetched instruction is discarded.
- Instruction format: byte0 = {opcode, operand}.
  - If opcode[3]==0, the instruction is long: byte1 = low 8 address bits, target = {operand, byte1}.
  - Otherwise the instruction is short (1 byte).
- States:
  - S_OP, halt=0:
    - ir <= rom_data; pc_enable=1.
    - next = S_ARG if rom_data[7]==0, else S_OUT.
  - S_OP, halt=1: no capture, pc_enable=0, stay in S_OP.
  - S_ARG: arg <= rom_data; pc_enable=1; next = S_OUT. halt is ignored here.
  - S_OUT:
    - instr_valid=1; opcode, operand, target and is_long held stable until accept.
    - Accept = instr_valid & instr_ready; on accept, next = S_OP.
    - If accept & is_long & branch_taken: pc_load=1, pc_load_val=target, pc_enable=0.
    - Otherwise pc_load=0.
    - No accept: stay in S_OUT; PC controls are 0.
- pc_enable, pc_load and pc_load_val are combinational from state and inputs.
  - pc_load_val = target whenever pc_load=0.
  - pc_enable and pc_load are never both 1.
- Latency: short instruction valid 1 cycle after its opcode is addressed; long instruction valid 2 cycles after.
- Throughput with instr_ready held at 1: one short instruction per 2 cycles, one long per 3 cycles.
- branch_taken is ignored for short instructions and in cycles without accept.
- Wrap-around: a long opcode at 0xFFF takes its arg byte from 0x000 (the PC wraps itself). No special handling.
- halt asserted in S_ARG or S_OUT does not abort the instruction; it takes effect at the next S_OP.

Optional Feature:
- Macro FETCH_INSTR_COUNT_EN.
- Defined:
  - Adds output port instr_count[15:0].
  - Reset value 0.
  - Increments by 1 on every accept; wraps 0xFFFF -> 0x0000.
  - Held at 0 during reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then short opcode 0x9A at 0x000 with ready=1:
  - cycle0: pc_enable=1.
  - cycle1: instr_valid=1, opcode=9, operand=A, is_long=0.
  - PC reaches 0x001.
- Long instruction 0x43,0x21 at 0x010, branch_taken=1, ready=1:
  - target=0x321 valid 2 cycles after opcode fetch.
  - pc_load=1, pc_load_val=0x321 on accept; next rom_addr=0x321.
- Same long instruction with branch_taken=0: pc_load=0; next fetch from 0x012.
- Backpressure: ready=0 for 5 cycles in S_OUT:
  - instr_valid stays 1; outputs stable; pc_enable=pc_load=0.
  - Accept on cycle 6.
- halt=1 in S_OP for 3 cycles: no capture, pc_enable=0, pc_in unchanged; resumes when halt=0.
- reset asserted while in S_ARG: next cycle state S_OP, instr_valid=0, PC controls 0; with FETCH_INSTR_COUNT_EN, instr_count=0.
